// File: rtl/status_pkg.sv
// -----------------------------------------------------------------------------
// status_pkg
// Shared definitions for the status reader block:
//   - bit positions inside the incoming status word
//   - bit positions inside the sticky flag vector
//   - read-handshake FSM state encoding
//   - default busy timeout
//   - sticky flag update helper (set has priority over clear)
// -----------------------------------------------------------------------------
package status_pkg;

  // Status word layout
  localparam int STATUS_W = 3;
  localparam int ST_DONE  = 0;
  localparam int ST_BUSY  = 1;
  localparam int ST_ERR   = 2;

  // Sticky flag layout
  localparam int NUM_FLAGS    = 4;
  localparam int FL_DONE      = 0;  // done rose
  localparam int FL_BUSY_FALL = 1;  // busy fell
  localparam int FL_ERR       = 2;  // error rose
  localparam int FL_TIMEOUT   = 3;  // busy stayed high too long

  // Read handshake FSM encoding
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_RESP = 1'b1;

  // Busy-high cycle count at which the timeout flag sets
  localparam int DEFAULT_TIMEOUT = 1000;

  // Sticky update: bits in clr drop, bits in set rise; a bit present in both
  // ends up set so an event landing in the acknowledge cycle is never lost.
  function automatic logic [NUM_FLAGS-1:0] flag_update(
    input logic [NUM_FLAGS-1:0] cur,
    input logic [NUM_FLAGS-1:0] clr,
    input logic [NUM_FLAGS-1:0] set
  );
    return (cur & ~clr) | set;
  endfunction

endpackage

// File: rtl/status_edge_det.sv
// -----------------------------------------------------------------------------
// status_edge_det
// Registers the status word once (s_q), keeps its previous value (s_qq) and
// reports per-bit rising and falling edges between the two.
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active-low
//   status  in   raw status word {error, busy, done}
//   s_q     out  registered status word
//   rise    out  per-bit rise of s_q (s_q=1, s_qq=0)
//   fall    out  per-bit fall of s_q (s_q=0, s_qq=1)
//
// After reset release the edge outputs stay quiet until s_qq holds a value
// that was really sampled from s_q, so a status bit already high at release
// does not look like a rising edge.
// -----------------------------------------------------------------------------
module status_edge_det
  import status_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [STATUS_W-1:0] status,
  output logic [STATUS_W-1:0] s_q,
  output logic [STATUS_W-1:0] rise,
  output logic [STATUS_W-1:0] fall
);

  logic [STATUS_W-1:0] s_qq;
  // armed_p0: s_q holds a post-reset sample; armed_p1: s_qq does too
  logic                armed_p0;
  logic                armed_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q      <= '0;
      s_qq     <= '0;
      armed_p0 <= 1'b0;
      armed_p1 <= 1'b0;
    end else begin
      s_q      <= status;
      s_qq     <= s_q;
      armed_p0 <= 1'b1;
      armed_p1 <= armed_p0;
    end
  end

  assign rise = armed_p1 ? (s_q & ~s_qq) : '0;
  assign fall = armed_p1 ? (~s_q & s_qq) : '0;

endmodule

// File: rtl/status_reader.sv
// -----------------------------------------------------------------------------
// status_reader
// Watches a 3-bit status register, turns its edges into sticky flags, measures
// how long busy stays high, raises a maskable interrupt and lets a host read a
// {last_busy_len, flags} snapshot through a req/ack handshake. Acknowledging a
// snapshot clears exactly the flags it reported.
//
// Parameters
//   TIMEOUT  busy-high cycle count at which the timeout flag sets
//   CNT_W    busy-length counter width (saturating)
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-low
//   status    in   {error, busy, done}
//   irq_mask  in   per-flag interrupt enable, 1 = enabled
//   rd_req    in   host read request (level)
//   rd_ack    in   host acknowledge of returned data
//   rd_valid  out  rd_data valid, held until acknowledged
//   rd_data   out  {last_busy_len, flags[3:0]} snapshot
//   irq       out  registered OR of (flags & irq_mask)
// -----------------------------------------------------------------------------
module status_reader
  import status_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [STATUS_W-1:0]        status,
  input  logic [NUM_FLAGS-1:0]       irq_mask,
  input  logic                       rd_req,
  input  logic                       rd_ack,
  output logic                       rd_valid,
  output logic [CNT_W+NUM_FLAGS-1:0] rd_data,
  output logic                       irq
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_MATCH = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: registered status and its edges
  // ---------------------------------------------------------------------------
  logic [STATUS_W-1:0] s_q;
  logic [STATUS_W-1:0] rise;
  logic [STATUS_W-1:0] fall;

  status_edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .status (status),
    .s_q    (s_q),
    .rise   (rise),
    .fall   (fall)
  );

  logic busy;
  logic busy_rise;
  logic busy_fall;
  logic unused_edges;

  assign busy      = s_q[ST_BUSY];
  assign busy_rise = rise[ST_BUSY];
  assign busy_fall = fall[ST_BUSY];
  assign unused_edges = ^{s_q[ST_DONE], s_q[ST_ERR], fall[ST_DONE], fall[ST_ERR]};

  // ---------------------------------------------------------------------------
  // Stage p1: busy-length counter, timeout detect, sticky flags, irq
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] busy_cnt_cur;
  logic [CNT_W-1:0] last_busy_len;
  logic             to_fired;
  logic             timeout_hit;

  // A rise restarts the episode; counting that same cycle makes an N-cycle
  // busy pulse end with the counter at N.
  assign busy_cnt_cur = busy_rise ? '0 : busy_cnt;

  // to_fired keeps a saturated counter from re-arming the flag within one
  // episode after a read has cleared it.
  assign timeout_hit = busy && (busy_cnt_cur == TO_MATCH) && (busy_rise || !to_fired);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt      <= '0;
      last_busy_len <= '0;
      to_fired      <= 1'b0;
    end else begin
      if (busy) begin
        busy_cnt <= sat_inc(busy_cnt_cur);
      end
      if (busy_rise) begin
        to_fired <= 1'b0;
      end
      if (timeout_hit) begin
        to_fired <= 1'b1;
      end
      if (busy_fall) begin
        last_busy_len <= busy_cnt;
      end
    end
  end

  logic [0:0]           rd_state;
  logic [NUM_FLAGS-1:0] flags;
  logic [NUM_FLAGS-1:0] flag_set;
  logic [NUM_FLAGS-1:0] flag_clr;

  always_comb begin
    flag_set               = '0;
    flag_set[FL_DONE]      = rise[ST_DONE];
    flag_set[FL_BUSY_FALL] = busy_fall;
    flag_set[FL_ERR]       = rise[ST_ERR];
    flag_set[FL_TIMEOUT]   = timeout_hit;

    // Only the flags that were reported get cleared; anything that arrived
    // after the snapshot stays pending for the next read.
    flag_clr = '0;
    if ((rd_state == RD_RESP) && rd_ack) begin
      flag_clr = rd_data[NUM_FLAGS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= '0;
      irq   <= 1'b0;
    end else begin
      flags <= flag_update(flags, flag_clr, flag_set);
      irq   <= |(flags & irq_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: read handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state <= RD_IDLE;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_req) begin
            rd_data  <= {last_busy_len, flags};
            rd_valid <= 1'b1;
            rd_state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rd_ack) begin
            rd_valid <= 1'b0;
            rd_state <= RD_IDLE;
          end
        end
        default: begin
          rd_valid <= 1'b0;
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_status_reader.sv
// -----------------------------------------------------------------------------
// tb_status_reader
// Two instances share one stimulus: dut0 with the default TIMEOUT (1000) and
// dut1 with TIMEOUT=8. A behavioural model tracks each instance in terms of
// status history, busy run length and sticky flags; a compare process checks
// every output of both instances each cycle. Directed scenarios add literal
// expectations on top.
// -----------------------------------------------------------------------------
module tb_status_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  status = 3'b000;
  logic [3:0]  irq_mask = 4'b0000;
  logic        rd_req = 1'b0;
  logic        rd_ack = 1'b0;

  logic        irq_w      [2];
  logic        rd_valid_w [2];
  logic [19:0] rd_data_w  [2];

  status_reader dut0 (
    .clk      (clk),
    .rst      (rst),
    .status   (status),
    .irq_mask (irq_mask),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_valid (rd_valid_w[0]),
    .rd_data  (rd_data_w[0]),
    .irq      (irq_w[0])
  );

  status_reader #(.TIMEOUT(8)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .status   (status),
    .irq_mask (irq_mask),
    .rd_req   (rd_req),
    .rd_ack   (rd_ack),
    .rd_valid (rd_valid_w[1]),
    .rd_data  (rd_data_w[1]),
    .irq      (irq_w[1])
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int          TOS [2] = '{1000, 8};
  logic [2:0]  m_sq    [2];  // last sampled status
  logic [2:0]  m_prev  [2];  // status sampled one cycle before that
  int          m_age   [2];  // samples taken since reset (capped at 2)
  int          m_run   [2];  // consecutive busy cycles seen so far
  logic [15:0] m_last  [2];
  logic [3:0]  m_flags [2];
  logic        m_resp  [2];
  logic [19:0] m_data  [2];
  logic        m_irq   [2];

  task automatic mreset(input int i);
    m_sq[i] = 3'b0; m_prev[i] = 3'b0; m_age[i] = 0; m_run[i] = 0;
    m_last[i] = 16'd0; m_flags[i] = 4'b0; m_resp[i] = 1'b0;
    m_data[i] = 20'd0; m_irq[i] = 1'b0;
  endtask

  task automatic mstep(input int i);
    logic [2:0] r;
    logic [2:0] f;
    logic [3:0] setv;
    logic [3:0] clr;
    int         k;
    // edges only count once both samples are real post-reset samples
    r = (m_age[i] >= 2) ? (m_sq[i] & ~m_prev[i]) : 3'b000;
    f = (m_age[i] >= 2) ? (~m_sq[i] & m_prev[i]) : 3'b000;
    // k = which busy cycle this is (1-based), 0 when busy is low
    k = m_sq[i][1] ? m_run[i] + 1 : 0;
    setv = {(m_sq[i][1] && (k == TOS[i])), r[2], f[1], r[0]};
    clr  = (m_resp[i] && rd_ack) ? m_data[i][3:0] : 4'b0000;
    m_irq[i] = |(m_flags[i] & irq_mask);
    if (!m_resp[i]) begin
      if (rd_req) begin
        m_data[i] = {m_last[i], m_flags[i]};
        m_resp[i] = 1'b1;
      end
    end else if (rd_ack) begin
      m_resp[i] = 1'b0;
    end
    if (f[1]) m_last[i] = 16'(m_run[i]);
    m_flags[i] = (m_flags[i] & ~clr) | setv;
    m_run[i]  = (k > 65535) ? 65535 : k;
    m_prev[i] = m_sq[i];
    m_sq[i]   = status;
    if (m_age[i] < 2) m_age[i]++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) mreset(i);
    forever begin
      @(posedge clk or negedge rst);
      for (int i = 0; i < 2; i++) begin
        if (!rst) mreset(i);
        else      mstep(i);
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_irq%0d", i),   32'(irq_w[i]),      32'(m_irq[i]));
        chk($sformatf("model_valid%0d", i), 32'(rd_valid_w[i]), 32'(m_resp[i]));
        chk($sformatf("model_data%0d", i),  32'(rd_data_w[i]),  32'(m_data[i]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    step(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", 32'(rd_valid_w[i]), 32'd0);
      chk("rst_data",  32'(rd_data_w[i]),  32'd0);
      chk("rst_irq",   32'(irq_w[i]),      32'd0);
    end
    rst = 1'b1;
    step(3);

    // one-cycle done pulse, done interrupt enabled
    irq_mask = 4'b0001;
    status = 3'b001; step(1); status = 3'b000; step(3);
    chk("done_irq", 32'(irq_w[0]), 32'd1);
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    chk("done_valid", 32'(rd_valid_w[0]), 32'd1);
    chk("done_flags", 32'(rd_data_w[0][3:0]), 32'h1);
    rd_ack = 1'b1; step(1); rd_ack = 1'b0; step(1);
    chk("done_irq_clr", 32'(irq_w[0]), 32'd0);

    // busy high 25 cycles
    irq_mask = 4'b0000;
    status = 3'b010; step(25); status = 3'b000; step(3);
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    chk("busy25_d0", 32'(rd_data_w[0]), 32'((25 << 4) | 4'b0010));
    chk("busy25_d1", 32'(rd_data_w[1]), 32'((25 << 4) | 4'b1010));
    rd_ack = 1'b1; step(1); rd_ack = 1'b0;

    // busy high 20 cycles, timeout flag on dut1 at busy cycle 8
    irq_mask = 4'b1000;
    status = 3'b010; step(9);
    chk("to_before", 32'(irq_w[1]), 32'd0);
    step(1);
    chk("to_at8", 32'(irq_w[1]), 32'd1);
    step(10); status = 3'b000; step(3);
    chk("to_stays", 32'(irq_w[1]), 32'd1);
    chk("to_none_d0", 32'(irq_w[0]), 32'd0);
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    chk("busy20_d0", 32'(rd_data_w[0]), 32'((20 << 4) | 4'b0010));
    chk("busy20_d1", 32'(rd_data_w[1]), 32'((20 << 4) | 4'b1010));
    rd_ack = 1'b1; step(1); rd_ack = 1'b0;
    irq_mask = 4'b0000;

    // snapshot 0101, error rises again in the ack cycle
    status = 3'b101; step(1); status = 3'b000; step(3);
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    chk("snap_0101", 32'(rd_data_w[0][3:0]), 32'h5);
    status = 3'b100; step(1);
    rd_ack = 1'b1; step(1); rd_ack = 1'b0; status = 3'b000; step(2);
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    chk("ack_set_wins", 32'(rd_data_w[0][3:0]), 32'h4);
    chk("len_kept", 32'(rd_data_w[0][19:4]), 32'd20);
    rd_ack = 1'b1; step(1); rd_ack = 1'b0;

    // ack withheld 10 cycles; rd_req and a 3-cycle busy pulse during RESP
    status = 3'b001; step(1); status = 3'b000; step(3);
    rd_req = 1'b1; step(1);
    status = 3'b010;
    for (int k = 0; k < 10; k++) begin
      chk("hold_valid", 32'(rd_valid_w[0]), 32'd1);
      chk("hold_data",  32'(rd_data_w[0]),  32'((20 << 4) | 4'b0001));
      if (k == 3) status = 3'b000;
      step(1);
    end
    rd_req = 1'b0; rd_ack = 1'b1; step(1);
    step(3); rd_ack = 1'b0;
    chk("idle_ack_valid", 32'(rd_valid_w[0]), 32'd0);
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    chk("resp_flag_kept", 32'(rd_data_w[0]), 32'((3 << 4) | 4'b0010));
    rd_ack = 1'b1; step(1); rd_ack = 1'b0;

    // reset in the middle of RESP with all status bits high through release
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    status = 3'b111; irq_mask = 4'b1111; step(2);
    rst = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_valid", 32'(rd_valid_w[i]), 32'd0);
      chk("midrst_data",  32'(rd_data_w[i]),  32'd0);
      chk("midrst_irq",   32'(irq_w[i]),      32'd0);
    end
    step(2); rst = 1'b1; step(5);
    for (int i = 0; i < 2; i++) chk("postrst_irq", 32'(irq_w[i]), 32'd0);
    rd_req = 1'b1; step(1); rd_req = 1'b0;
    for (int i = 0; i < 2; i++) chk("postrst_data", 32'(rd_data_w[i]), 32'd0);
    rd_ack = 1'b1; step(1); rd_ack = 1'b0; status = 3'b000;
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
